// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: turns the CPU's four-phase request strobe into either an
// acknowledge-driven memory access, a fixed-wait I/O register access, or an
// unmapped-space error completion. Memory accesses are guarded by a timeout.
module cpu_bus_bridge #(
  parameter logic [31:0] MEM_SIZE = 32'h0010_0000,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_FF00,
  parameter logic [31:0] IO_MASK  = 32'hFFFF_FF00,
  parameter int          IO_WAIT  = 3,
  parameter int          TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_clk,
  input  logic        i_bus_we,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_io_sel,
  output logic        o_io_we,
  output logic [7:0]  o_io_addr,
  output logic [31:0] o_io_wdata,
  input  logic [31:0] i_io_rdata,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_IO_WAIT  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Terminal counts of the shared wait counter (counter starts at 0 on entry).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] IO_LAST = 8'(IO_WAIT - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic        ready_q;
  logic        mem_req_q;
  logic        io_sel_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic        io_hit;
  logic        mem_hit;

  // Address decode of the incoming request; the I/O window wins over memory.
  always_comb begin
    io_hit  = (i_bus_addr & IO_MASK) == IO_BASE;
    mem_hit = i_bus_addr < MEM_SIZE;
  end

  // Transaction FSM; all strobes are registered so they are glitch-free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
      io_sel_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_bus_clk) begin
            addr_q  <= i_bus_addr;
            we_q    <= i_bus_we;
            wdata_q <= i_bus_wdata;
            cnt_q   <= '0;
            if (io_hit) begin
              io_sel_q <= 1'b1;
              state_q  <= S_IO_WAIT;
            end else if (mem_hit) begin
              mem_req_q <= 1'b1;
              state_q   <= S_MEM_WAIT;
            end else begin
              // Unmapped: complete at once with an error; reads float high.
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              if (!i_bus_we) rdata_q <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end
          end
        end
        S_MEM_WAIT: begin
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            ready_q   <= 1'b1;
            if (!we_q) rdata_q <= i_mem_rdata;
            state_q   <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            // Target never answered: abandon the request and report it.
            mem_req_q <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            if (!we_q) rdata_q <= 32'hFFFF_FFFF;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_IO_WAIT: begin
          if (cnt_q == IO_LAST) begin
            io_sel_q <= 1'b0;
            ready_q  <= 1'b1;
            if (!we_q) rdata_q <= i_io_rdata;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          // Hold ready until the CPU lowers its strobe; an early drop
          // therefore yields exactly one ready cycle.
          if (!i_bus_clk) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_bus_rdata = rdata_q;
  assign o_bus_ready = ready_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_io_sel    = io_sel_q;
  assign o_io_we     = we_q;
  assign o_io_addr   = addr_q[7:0];
  assign o_io_wdata  = wdata_q;
  assign o_err       = err_q;
  assign o_busy      = state_q != S_IDLE;

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Downstream bus stage for the 6502/65832-compatible `cpu`. It consumes the CPU's request-level bus strobe (`o_bus_clk`, `o_bus_we`, `o_bus_addr`, `o_bus_data`) and returns `i_bus_data` and `i_bus_data_ready`. Each request is decoded into one of three targets: an acknowledge-driven memory port, a fixed-wait-state I/O register window, or unmapped space. The CPU side uses a four-phase handshake, and a timeout guards memory accesses that are never acknowledged.

## Interface
Parameters:
- `MEM_SIZE`, `32'h0010_0000`: memory region is `addr < MEM_SIZE`.
- `IO_BASE`, `32'hFFFF_FF00`: I/O window base.
- `IO_MASK`, `32'hFFFF_FF00`: the I/O window hits when `(addr & IO_MASK) == IO_BASE`. This check takes priority over memory.
- `IO_WAIT`, 3: cycles `o_io_sel` is held. Legal range is 1..15.
- `TIMEOUT`, 255: maximum `MEM_WAIT` cycles before the bridge forces completion. Legal range is 1..255.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_bus_clk`, in, 1: CPU request level (from `o_bus_clk`).
- `i_bus_we`, in, 1: 1 = write.
- `i_bus_addr`, in, 32: byte address.
- `i_bus_wdata`, in, 32: write data.
- `o_bus_rdata`, out, 32: read data to the CPU.
- `o_bus_ready`, out, 1: transaction complete.
- `o_mem_req`, out, 1: memory request, held until ack.
- `o_mem_we`, out, 1: memory write enable.
- `o_mem_addr`, out, 32: memory address.
- `o_mem_wdata`, out, 32: memory write data.
- `i_mem_rdata`, in, 32: memory read data, valid with ack.
- `i_mem_ack`, in, 1: memory acknowledge.
- `o_io_sel`, out, 1: I/O select.
- `o_io_we`, out, 1: I/O write.
- `o_io_addr`, out, 8: `addr[7:0]`.
- `o_io_wdata`, out, 32: I/O write data.
- `i_io_rdata`, in, 32: I/O read data, sampled on the last select cycle.
- `o_err`, out, 1: one-cycle pulse on timeout or unmapped access.
- `o_busy`, out, 1: state ≠ IDLE.

## Operation
- **States:** IDLE, MEM_WAIT, IO_WAIT, DONE.
- **IDLE:**
  - When `i_bus_clk` = 1 is sampled, latch addr, we and wdata, then decode.
  - I/O hit → IO_WAIT. Memory hit → MEM_WAIT. Otherwise → DONE with `o_err` pulse.
- **MEM_WAIT:**
  - `o_mem_req` = 1; address, we and wdata come from the latch.
  - When `i_mem_ack` = 1 is sampled: capture `i_mem_rdata` if it is a read, drop `o_mem_req`, go to DONE.
  - A wait counter resets on entry and increments each cycle without ack. When it reaches `TIMEOUT`: drop the request, force read data to `32'hFFFF_FFFF` (reads only), pulse `o_err`, go to DONE.
- **IO_WAIT:**
  - `o_io_sel` = 1 for exactly `IO_WAIT` cycles.
  - On the last cycle, capture `i_io_rdata` if it is a read, then go to DONE.
  - Writes take effect on every select cycle; the target treats them as idempotent.
- **DONE:**
  - `o_bus_ready` = 1 and `o_bus_rdata` is stable.
  - When `i_bus_clk` = 0 is sampled, drop `o_bus_ready` and return to IDLE.
- **Read data:**
  - `o_bus_rdata` updates only on read completion.
  - Writes leave the previous value unchanged.
  - Unmapped reads return `32'hFFFF_FFFF`.
- **Abort (CPU drops `i_bus_clk` before ready):** the bridge does not cancel. The transaction runs to DONE, ready is asserted for exactly one cycle, then the bridge returns to IDLE.
- **Ack in IDLE, IO_WAIT or DONE:** ignored.
- **Reset values (asynchronous):**
  - State = IDLE.
  - All outputs 0, including `o_bus_rdata`, `o_mem_req` and `o_io_sel`.
  - An outstanding memory request is dropped immediately.

## Timing
- Request sampled at edge N:
  - Memory: `o_mem_req` is high from N+1. Ack sampled at edge M → `o_mem_req` low and `o_bus_ready` high from M+1. Minimum request-to-ready latency is 2 cycles (ack present in the first `MEM_WAIT` cycle).
  - I/O: `o_io_sel` is high for cycles N+1..N+`IO_WAIT`, and ready is high from N+`IO_WAIT`+1.
  - Unmapped: ready and `o_err` are high from N+1.
  - Timeout: with no ack, ready is high from N+1+`TIMEOUT`, with `o_err` pulsing in that same cycle.
- Ready release: `i_bus_clk` = 0 sampled at edge K → ready low from K+1.
- Next request: earliest acceptance is at edge K+1 or later.
- Back-to-back rule: `i_bus_clk` must be seen low in DONE before a new request is accepted, so the bridge never double-accepts.

## Test plan
- **Memory read:** read addr `0x0000_1234`; memory acks 2 cycles after req with `0xDEADBEEF` → `o_mem_req` high for 2 cycles, ready 1 cycle after ack, `o_bus_rdata` = `0xDEADBEEF`, ready drops 1 cycle after `i_bus_clk` falls.
- **I/O write:** `IO_WAIT`=3, write `0x55` to `0xFFFF_FF10` → `o_io_sel` high exactly 3 cycles, `o_io_addr` = `0x10`, `o_io_wdata` = `0x55`, `o_io_we` = 1, `o_bus_rdata` unchanged.
- **Unmapped read:** read `0x8000_0000` → ready and `o_err` high one cycle after request, rdata = `0xFFFF_FFFF`, no mem/io strobes.
- **Timeout:** `TIMEOUT`=4, memory never acks → ready at request+5 cycles, `o_err` single-cycle pulse, rdata = `0xFFFF_FFFF`, `o_mem_req` low.
- **Abort:** `i_bus_clk` drops during `MEM_WAIT`; ack later → ready high exactly 1 cycle, then IDLE, `o_busy` = 0.
- **Reset mid-operation:** assert `i_rst` during `MEM_WAIT` → `o_mem_req`, `o_bus_ready` and `o_busy` go to 0 without a clock edge; after release, a new memory read completes normally.
